// File: rtl/quad_decode.sv
// -----------------------------------------------------------------------------
// quad_decode
//   Quadrature (A/B) incremental-encoder decoder with x4 resolution.
//   Each encoder pin passes through a synchroniser and a glitch filter. Every
//   legal Gray-code step of the filtered pair then moves a signed position
//   counter by one and records the direction of that step.
//
// Parameters
//   SYNC_STAGES    synchroniser depth per channel (>= 2)
//   FILTER_CYCLES  consecutive differing samples needed to accept a new level (>= 1)
//   POS_WIDTH      position counter width (kept at 16 to match o_Position)
//
// Ports
//   Clk          in   1   system clock, rising edge
//   i_sClr       in   1   synchronous reset, active-high, overrides everything
//   i_A          in   1   encoder channel A (asynchronous to Clk)
//   i_B          in   1   encoder channel B (asynchronous to Clk)
//   i_setOrigin  in   1   load position with zero at this edge
//   o_Direction  out  1   1 = last legal step forward, 0 = reverse
//   o_Position   out  16  two's-complement position, bit 0 is the MSB
// -----------------------------------------------------------------------------
module quad_decode #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int POS_WIDTH     = 16
) (
  input  logic        Clk,
  input  logic        i_sClr,
  input  logic        i_A,
  input  logic        i_B,
  input  logic        i_setOrigin,
  output logic        o_Direction,
  output logic [0:15] o_Position
);

  // The filter counter only has to reach FILTER_CYCLES-1, because the
  // acceptance happens on the edge that would have reached FILTER_CYCLES.
  localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_FWD  = 2'b01;
  localparam logic [1:0] STEP_REV  = 2'b10;

  // Channel index 1 is A and index 0 is B, so the filtered pair reads as {A,B}.
  logic [1:0]             pin_s;
  logic [SYNC_STAGES-1:0] sync_r     [2];
  logic [CNT_W-1:0]       filt_cnt_r [2];
  logic [1:0]             filt_r;
  logic [1:0]             prev_r;
  logic [1:0]             step_s;
  logic [POS_WIDTH-1:0]   pos_r;
  logic                   dir_r;

  assign pin_s = {i_A, i_B};

  // Synchronise each pin and accept a new level after a run of differing samples.
  always_ff @(posedge Clk) begin
    if (i_sClr) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_r[ch]     <= '0;
        filt_cnt_r[ch] <= '0;
      end
      filt_r <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_r[ch] <= {sync_r[ch][SYNC_STAGES-2:0], pin_s[ch]};
        if (sync_r[ch][SYNC_STAGES-1] == filt_r[ch]) begin
          // Any sample that agrees with the accepted level restarts the run.
          filt_cnt_r[ch] <= '0;
        end else if (filt_cnt_r[ch] == CNT_LAST) begin
          filt_r[ch]     <= sync_r[ch][SYNC_STAGES-1];
          filt_cnt_r[ch] <= '0;
        end else begin
          filt_cnt_r[ch] <= filt_cnt_r[ch] + CNT_ONE;
        end
      end
    end
  end

  // Classify the transition from the previous to the current filtered state.
  always_comb begin
    step_s = STEP_NONE;
    case ({prev_r, filt_r})
      // A leads B: 00 -> 10 -> 11 -> 01 -> 00
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_s = STEP_FWD;
      // B leads A: 00 -> 01 -> 11 -> 10 -> 00
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_s = STEP_REV;
      // No change, or both bits flipped in one clock (not countable).
      default:                                step_s = STEP_NONE;
    endcase
  end

  // Update the previous state, the position counter and the direction flag.
  always_ff @(posedge Clk) begin
    if (i_sClr) begin
      prev_r <= 2'b00;
      pos_r  <= '0;
      dir_r  <= 1'b0;
    end else begin
      // The previous state follows every clock, including after an illegal jump,
      // so the next legal step is judged from where the encoder really is.
      prev_r <= filt_r;

      case (step_s)
        STEP_FWD: dir_r <= 1'b1;
        STEP_REV: dir_r <= 1'b0;
        default:  dir_r <= dir_r;
      endcase

      // Setting the origin wins over a step on the same edge; the step is lost
      // from the count but still reported through the direction flag.
      if (i_setOrigin) begin
        pos_r <= '0;
      end else if (step_s == STEP_FWD) begin
        pos_r <= pos_r + POS_ONE;
      end else if (step_s == STEP_REV) begin
        pos_r <= pos_r - POS_ONE;
      end else begin
        pos_r <= pos_r;
      end
    end
  end

  assign o_Position  = pos_r;
  assign o_Direction = dir_r;

endmodule

// File: tb/tb_quad_decode.sv
// -----------------------------------------------------------------------------
// tb_quad_decode
//   Drives quad_decode one clock at a time. For every clock a reference model
//   predicts {direction, position} and pushes it into a queue. An independent
//   monitor pops one entry per clock and compares it with the DUT outputs.
//   Directed phases cover reset, forward/reverse counting, glitch rejection,
//   illegal jumps, wrap and origin. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_quad_decode;

  localparam int SS = 2;
  localparam int FC = 2;

  typedef struct packed {
    logic        d;
    logic [15:0] p;
  } exp_t;

  logic        clk = 1'b0;
  logic        sclr;
  logic        a;
  logic        b;
  logic        org;
  logic        dir;
  logic [0:15] pos;

  always #5 clk = ~clk;

  quad_decode #(
    .SYNC_STAGES  (SS),
    .FILTER_CYCLES(FC),
    .POS_WIDTH    (16)
  ) dut (
    .Clk        (clk),
    .i_sClr     (sclr),
    .i_A        (a),
    .i_B        (b),
    .i_setOrigin(org),
    .o_Direction(dir),
    .o_Position (pos)
  );

  // Reference model state: pin history (bit j = sample taken j clocks ago),
  // accepted levels, previously seen accepted state, position and direction.
  logic [7:0]  ha;
  logic [7:0]  hb;
  logic        m_fa;
  logic        m_fb;
  logic [1:0]  m_prev;
  logic [15:0] m_pos;
  logic        m_dir;
  // Position of each {A,B} state along the forward cycle 00,10,11,01.
  int          gidx [4] = '{0, 3, 1, 2};

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // A new level is accepted once the last FC synchronised samples all disagree
  // with the currently accepted level.
  function automatic bit window_flips(input logic [7:0] h, input logic lvl);
    for (int j = 0; j < FC; j++) begin
      if (h[SS + j] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply one clock's worth of inputs, predict the outputs after that edge.
  task automatic drive(input logic na, input logic nb, input logic norg, input logic nclr);
    logic [1:0] cur;
    int         d;
    a    = na;
    b    = nb;
    org  = norg;
    sclr = nclr;
    if (nclr) begin
      ha     = 8'h00;
      hb     = 8'h00;
      m_fa   = 1'b0;
      m_fb   = 1'b0;
      m_prev = 2'b00;
      m_pos  = 16'h0000;
      m_dir  = 1'b0;
    end else begin
      cur = {m_fa, m_fb};
      d   = (gidx[cur] - gidx[m_prev] + 4) % 4;
      if (d == 1) begin
        m_dir = 1'b1;
        m_pos = m_pos + 16'd1;
      end else if (d == 3) begin
        m_dir = 1'b0;
        m_pos = m_pos - 16'd1;
      end
      if (norg) m_pos = 16'h0000;
      m_prev = cur;
      ha = {ha[6:0], na};
      hb = {hb[6:0], nb};
      if (window_flips(ha, m_fa)) m_fa = ~m_fa;
      if (window_flips(hb, m_fb)) m_fb = ~m_fb;
    end
    exp_q.push_back('{d: m_dir, p: m_pos});
    @(negedge clk);
  endtask

  task automatic hold(input logic na, input logic nb, input int n);
    for (int i = 0; i < n; i++) drive(na, nb, 1'b0, 1'b0);
  endtask

  // Directed check against a value fixed by the intended behaviour.
  task automatic check_const(input string name, input logic [15:0] ep, input logic ed);
    n_cmp++;
    if ({dir, pos} !== {ed, ep}) begin
      n_bad++;
      $display("FAIL %s: got pos=%h dir=%b, expected pos=%h dir=%b", name, pos, dir, ep, ed);
    end
  endtask

  // Monitor: one expected entry per clock, compared shortly after the edge.
  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (!done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty at %0t: got pos=%h dir=%b, expected an entry", $time, pos, dir);
        end else begin
          e = exp_q.pop_front();
          if ({dir, pos} !== {e.d, e.p}) begin
            n_bad++;
            $display("FAIL cycle_check at %0t: got pos=%h dir=%b, expected pos=%h dir=%b",
                     $time, pos, dir, e.p, e.d);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0] fwd_seq [4];
    logic [1:0] s;
    logic       ra;
    logic       rb;
    int         ra_left;
    int         rb_left;

    fwd_seq[0] = 2'b10;
    fwd_seq[1] = 2'b11;
    fwd_seq[2] = 2'b01;
    fwd_seq[3] = 2'b00;

    // Reset held with both pins high; the 00 -> 11 jump after release is illegal.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
    check_const("reset_state", 16'h0000, 1'b0);
    hold(1'b1, 1'b1, 10);
    check_const("reset_release_11", 16'h0000, 1'b0);
    hold(1'b0, 1'b0, 10);
    check_const("back_to_00", 16'h0000, 1'b0);

    // Forward sequence, with the first increment timed against the pin edge.
    hold(1'b1, 1'b0, 4);
    check_const("fwd_latency_before", 16'h0000, 1'b0);
    hold(1'b1, 1'b0, 1);
    check_const("fwd_latency_after", 16'h0001, 1'b1);
    hold(1'b1, 1'b0, 5);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    check_const("forward_4", 16'h0004, 1'b1);

    // Reverse sequence through zero to -1.
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 10);
    check_const("reverse_to_minus1", 16'hFFFF, 1'b0);

    // Glitches on A: one clock is rejected, two clocks count up and back.
    hold(1'b0, 1'b0, 10);
    check_const("glitch_pre", 16'h0000, 1'b1);
    hold(1'b1, 1'b0, 1);
    hold(1'b0, 1'b0, 10);
    check_const("glitch_1clk", 16'h0000, 1'b1);
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 10);
    check_const("glitch_2clk", 16'h0000, 1'b0);

    // Illegal double-bit jumps in both directions.
    hold(1'b1, 1'b1, 10);
    check_const("illegal_00_11", 16'h0000, 1'b0);
    hold(1'b0, 1'b0, 10);
    check_const("illegal_11_00", 16'h0000, 1'b0);

    // Fast forward run to the signed boundary, one step per clock.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 32767; i++) begin
      s = fwd_seq[i % 4];
      drive(s[1], s[0], 1'b0, 1'b0);
    end
    hold(1'b0, 1'b1, 6);
    check_const("reach_7fff", 16'h7FFF, 1'b1);
    hold(1'b0, 1'b0, 6);
    check_const("wrap_8000", 16'h8000, 1'b1);

    // Origin coincident with a step: the step is dropped from the count.
    hold(1'b1, 1'b0, 4);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check_const("origin_coincident", 16'h0000, 1'b1);
    hold(1'b1, 1'b0, 5);
    hold(1'b1, 1'b1, 6);
    check_const("origin_next_step", 16'h0001, 1'b1);

    // Randomized pins with independent hold lengths, occasional origin/reset.
    ra      = 1'b1;
    rb      = 1'b1;
    ra_left = 0;
    rb_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ra_left == 0) begin
        ra      = 1'($urandom_range(0, 1));
        ra_left = $urandom_range(1, 4);
      end
      if (rb_left == 0) begin
        rb      = 1'($urandom_range(0, 1));
        rb_left = $urandom_range(1, 4);
      end
      ra_left--;
      rb_left--;
      drive(ra, rb, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end

    done = 1'b1;
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
